spram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port RAM (one access per cycle, 1-cycle registered read latency) between NUM_REQ requesters, each issuing reads or writes over a valid/ready handshake. It drives the RAM address/data/write-enable directly and returns read data through a fixed-latency response pipeline tagged per requester. An optional bounded lock lets one requester own consecutive cycles for bursts, for example a FIFO writer draining a line, without starving the others.

---
 rtl/spram_rr_arbiter_pkg.sv | 15 +
 rtl/spram_rr_arbiter_if.sv | 28 ++
 rtl/spram_rr_arbiter_rr_priority_picker.sv | 36 +++
 rtl/spram_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_spram_rr_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_rr_arbiter_pkg.sv
// Shared types for the single-port RAM round-robin arbiter:
// requester id and read-pipeline stage record.
package spram_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned ID_W    = $clog2(MAX_REQ);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_stage_t;

endpackage

// File: rtl/spram_rr_arbiter_if.sv
// Requester-side bundle: per-requester request handshake plus the shared
// tagged read-response bus.
interface spram_rr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = 8
);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0]                 req_lock;
    logic [NUM_REQ-1:0][AW-1:0]         req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_data;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/spram_rr_arbiter_rr_priority_picker.sv
// Rotating-priority one-hot select: first set bit at or after start,
// wrapping to the lowest set bit below start.
module rr_priority_picker
    import spram_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] vec,
    input  req_id_t      start,
    output logic [N-1:0] grant,
    output req_id_t      idx,
    output logic         any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // pass 1 covers [start, N), pass 2 the wrapped part [0, start)
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && vec[i] && (ID_W'(i) >= start)) begin
                grant[i] = 1'b1;
                idx      = ID_W'(i);
                any      = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && vec[i]) begin
                grant[i] = 1'b1;
                idx      = ID_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
// with a bounded burst lock and a 2-cycle tagged read-response pipeline.
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned RAM_DEPTH  = 256,
    parameter  int unsigned LOCK_MAX   = 8,
    localparam int unsigned AW         = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    spram_rr_arbiter_if.slave     bus,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int unsigned    CW        = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_MAX - 1);

    req_id_t               rr_ptr_q,     rr_ptr_d;
    logic                  locked_q,     locked_d;
    req_id_t               lock_owner_q, lock_owner_d;
    logic [CW-1:0]         lock_cnt_q,   lock_cnt_d;
    rd_stage_t             s0_q,         s0_d;
    rd_stage_t             s1_q,         s1_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,   rsp_data_d;

    logic                  active;
    logic                  fire;
    logic                  beat_we;
    logic                  beat_lock;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    req_id_t               pick_idx;
    logic                  pick_any;

    // While locked only the owner is eligible, so an idle owner stalls everyone.
    always_comb begin
        active   = !(rst || clear);
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (!locked_q || (lock_owner_q == ID_W'(i)));
        end
    end

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .vec   (eligible),
        .start (rr_ptr_q),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        fire      = active && pick_any;
        beat_we   = 1'b0;
        beat_lock = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (fire && grant[i]) begin
                beat_we   = bus.req_we[i];
                beat_lock = bus.req_lock[i];
                mem_addr  = bus.req_addr[i];
                mem_din   = bus.req_wdata[i];
            end
        end
        mem_wr_en     = fire && beat_we;
        bus.req_ready = fire ? grant : '0;

        rr_ptr_d     = rr_ptr_q;
        locked_d     = locked_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (fire) begin
            if (beat_lock && (lock_cnt_q < LOCK_LAST)) begin
                locked_d     = 1'b1;
                lock_owner_d = pick_idx;
                lock_cnt_d   = lock_cnt_q + 1'b1;
            end else begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
                rr_ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end

        s0_d.valid = fire && !beat_we;
        s0_d.id    = pick_idx;
        s1_d       = s0_q;
        rsp_data_d = mem_dout;

        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = s1_q.valid && (s1_q.id == ID_W'(i));
        end
        bus.rsp_data = rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rr_ptr_q     <= '0;
            locked_q     <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            rsp_data_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter with a behavioural single-port RAM
// (registered read) attached to the mem_* ports.
module tb_spram_rr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] ram [256];

    int total = 0;
    int bad   = 0;

    spram_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .AW(AW)) bus ();

    spram_rr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (256),
        .LOCK_MAX   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wr_en (mem_wr_en),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i]  = AW'(i);
            bus.req_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        clear = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_valid = '1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.req_ready !== 4'b0000) begin
                $display("FAIL reset_ready c=%0d got=%b exp=0000", c, bus.req_ready); bad++;
            end
            total++;
            if (mem_wr_en !== 1'b0) begin
                $display("FAIL reset_wr_en c=%0d got=%b exp=0", c, mem_wr_en); bad++;
            end
            total++;
            if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 8'h00) begin
                $display("FAIL reset_rsp c=%0d got=%b/%h exp=0000/00", c, bus.rsp_valid, bus.rsp_data); bad++;
            end
            total++;
            if (mem_addr !== 8'h00 || mem_din !== 8'h00) begin
                $display("FAIL reset_mem c=%0d got=%h/%h exp=00/00", c, mem_addr, mem_din); bad++;
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready); bad++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy, exp_rsp;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
            total++;
            if (bus.req_ready !== exp_rdy) begin
                $display("FAIL rr_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); bad++;
            end
            if (c < 8) begin
                total++;
                if (mem_addr !== 8'(c % 4)) begin
                    $display("FAIL rr_addr c=%0d got=%h exp=%h", c, mem_addr, 8'(c % 4)); bad++;
                end
            end
            exp_rsp = (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'h0;
            total++;
            if (bus.rsp_valid !== exp_rsp) begin
                $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_rsp); bad++;
            end
            if (c >= 2) begin
                total++;
                if (bus.rsp_data !== 8'(48 + (c - 2) % 4)) begin
                    $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, bus.rsp_data, 8'(48 + (c - 2) % 4)); bad++;
                end
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        @(negedge clk);
        bus.req_valid    = 4'b0100;
        bus.req_we       = 4'b0100;
        bus.req_addr[2]  = 8'h10;
        bus.req_wdata[2] = 8'hA5;
        #1;
        total++;
        if (bus.req_ready !== 4'b0100 || mem_wr_en !== 1'b1 || mem_addr !== 8'h10 || mem_din !== 8'hA5) begin
            $display("FAIL wr_beat got=%b/%b/%h/%h exp=0100/1/10/a5", bus.req_ready, mem_wr_en, mem_addr, mem_din); bad++;
        end
        @(negedge clk);
        bus.req_we = 4'b0000;
        #1;
        total++;
        if (bus.req_ready !== 4'b0100 || mem_wr_en !== 1'b0 || mem_addr !== 8'h10) begin
            $display("FAIL rd_beat got=%b/%b/%h exp=0100/0/10", bus.req_ready, mem_wr_en, mem_addr); bad++;
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        total++;
        if (bus.rsp_valid !== 4'b0000) begin
            $display("FAIL wr_no_rsp got=%b exp=0000", bus.rsp_valid); bad++;
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 8'hA5) begin
            $display("FAIL raw_rsp got=%b/%h exp=0100/a5", bus.rsp_valid, bus.rsp_data); bad++;
        end
    endtask

    task automatic test_lock_bound();
        logic [3:0] exp_seq [7];
        exp_seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus.req_valid = 4'hF;
            bus.req_lock  = 4'b0010;
            #1;
            total++;
            if (bus.req_ready !== exp_seq[c]) begin
                $display("FAIL lock_bound c=%0d got=%b exp=%b", c, bus.req_ready, exp_seq[c]); bad++;
            end
        end
    endtask

    task automatic test_locked_idle();
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b1000;
        bus.req_lock  = 4'b1000;
        #1;
        total++;
        if (bus.req_ready !== 4'b1000) begin
            $display("FAIL idle_lock_take got=%b exp=1000", bus.req_ready); bad++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req_valid    = 4'b0001;
            bus.req_we       = 4'b0001;
            bus.req_addr[0]  = 8'h20;
            bus.req_wdata[0] = 8'h5A;
            #1;
            total++;
            if (bus.req_ready !== 4'b0000 || mem_wr_en !== 1'b0) begin
                $display("FAIL idle_owner_stall c=%0d got=%b/%b exp=0000/0", c, bus.req_ready, mem_wr_en); bad++;
            end
        end
        @(negedge clk);
        bus.req_valid = 4'b1001;
        #1;
        total++;
        if (bus.req_ready !== 4'b1000) begin
            $display("FAIL idle_resume got=%b exp=1000", bus.req_ready); bad++;
        end
        @(negedge clk);
        bus.req_lock = 4'b0000;
        #1;
        total++;
        if (bus.req_ready !== 4'b1000) begin
            $display("FAIL idle_release_beat got=%b exp=1000", bus.req_ready); bad++;
        end
        @(negedge clk);
        bus.req_valid = 4'b0001;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001 || mem_wr_en !== 1'b1) begin
            $display("FAIL idle_after_release got=%b/%b exp=0001/1", bus.req_ready, mem_wr_en); bad++;
        end
    endtask

    task automatic test_clear();
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        total++;
        if (bus.req_ready !== 4'b0010) begin
            $display("FAIL clr_read_beat got=%b exp=0010", bus.req_ready); bad++;
        end
        @(negedge clk);
        clear         = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_we    = 4'hF;
        #1;
        total++;
        if (bus.req_ready !== 4'b0000 || mem_wr_en !== 1'b0) begin
            $display("FAIL clr_cycle got=%b/%b exp=0000/0", bus.req_ready, mem_wr_en); bad++;
        end
        @(negedge clk);
        clear      = 1'b0;
        bus.req_we = 4'h0;
        #1;
        total++;
        if (bus.rsp_valid !== 4'b0000) begin
            $display("FAIL clr_rsp_dropped got=%b exp=0000", bus.rsp_valid); bad++;
        end
        total++;
        if (bus.req_ready !== 4'b0001) begin
            $display("FAIL clr_ptr_reset got=%b exp=0001", bus.req_ready); bad++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(48 + i);
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock_bound();
        test_locked_idle();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
